// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit sequencer producing registered line-source select, serial bit and parity
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [1:0]            mux_sel,
  output logic                  ser_data,
  output logic                  par_bit,
  output logic                  busy
);
  localparam int CW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t                r_state, w_state_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_par_en;
  logic [1:0]            w_mux_nxt;
  logic                  w_busy_nxt, w_accept, w_last;
  assign w_accept = (r_state == IDLE) && Data_Valid;
  assign w_last   = r_cnt == CW'(DATA_WIDTH - 1);
  // state register; outputs are registered from the decode of the upcoming state
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      mux_sel <= 2'b01;
      busy    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      mux_sel <= w_mux_nxt;
      busy    <= w_busy_nxt;
    end
  end
  // shadow capture at acceptance, bit counter and serial bit while in DATA
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_data   <= '0;
      r_par_en <= 1'b0;
      par_bit  <= 1'b0;
      r_cnt    <= '0;
      ser_data <= 1'b0;
    end else begin
      if (w_accept) begin
        r_data   <= P_DATA;
        r_par_en <= PAR_EN;
        par_bit  <= ^P_DATA ^ PAR_TYP;
      end
      if (w_state_nxt == DATA) begin
        r_cnt    <= w_cnt_nxt;
        ser_data <= r_data[w_cnt_nxt];
      end
    end
  end
  // next-state decode; parity state is skipped when the latched enable is low
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = Data_Valid ? START : IDLE;
      START:   w_state_nxt = DATA;
      DATA:    w_state_nxt = w_last ? (r_par_en ? PARITY : STOP) : DATA;
      PARITY:  w_state_nxt = STOP;
      STOP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end
  // output decode of the upcoming state; counter restarts on entry to DATA
  always_comb begin
    w_mux_nxt  = w_state_nxt == START  ? 2'b00 :
                 w_state_nxt == DATA   ? 2'b10 :
                 w_state_nxt == PARITY ? 2'b11 : 2'b01;
    w_busy_nxt = w_state_nxt != IDLE;
    w_cnt_nxt  = r_state == DATA ? r_cnt + CW'(1) : '0;
  end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: frame-level reference model with per-cycle comparison plus directed literal frames
module tb_uart_tx_ctrl;
  localparam int W = 8;
  logic         CLK = 1'b0;
  logic         RST, Data_Valid, PAR_EN, PAR_TYP;
  logic [W-1:0] P_DATA;
  logic [1:0]   mux_sel;
  logic         ser_data, par_bit, busy;
  int           checks = 0;
  int           errors = 0;

  uart_tx_ctrl #(.DATA_WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .mux_sel(mux_sel),
    .ser_data(ser_data), .par_bit(par_bit), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: on acceptance the whole frame is expanded into a queue of line selects
  logic [1:0] q_mux[$];
  logic       q_bit[$];
  logic [1:0] e_mux;
  logic       e_ser, e_par, e_busy;
  bit         live = 0;

  initial forever begin
    @(posedge CLK);
    if (RST) begin
      q_mux.delete();
      q_bit.delete();
      e_mux = 2'b01; e_ser = 1'b0; e_par = 1'b0; e_busy = 1'b0; live = 1;
    end else if (live) begin
      if (!e_busy && Data_Valid) begin
        q_mux.push_back(2'b00);
        for (int i = 0; i < W; i++) begin
          q_mux.push_back(2'b10);
          q_bit.push_back(P_DATA[i]);
        end
        if (PAR_EN) q_mux.push_back(2'b11);
        q_mux.push_back(2'b01);
        e_par = (^P_DATA) ^ PAR_TYP;
      end
      if (q_mux.size() > 0) begin
        e_mux  = q_mux.pop_front();
        e_busy = 1'b1;
        if (e_mux == 2'b10) e_ser = q_bit.pop_front();
      end else begin
        e_mux  = 2'b01;
        e_busy = 1'b0;
      end
    end
  end

  initial forever begin
    @(negedge CLK);
    if (live) begin
      chk("mux_sel", {30'd0, mux_sel}, {30'd0, e_mux});
      chk("ser_data", {31'd0, ser_data}, {31'd0, e_ser});
      chk("par_bit", {31'd0, par_bit}, {31'd0, e_par});
      chk("busy", {31'd0, busy}, {31'd0, e_busy});
    end
  end

  task automatic run_frame(input logic [W-1:0] d, input logic pe, input logic pt,
                           input int inj, input int exp_len, input logic exp_par,
                           output logic [63:0] trace, output logic [W-1:0] bits);
    int n = 0;
    trace = '0;
    bits  = '0;
    @(negedge CLK);
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; Data_Valid = 1'b1;
    @(negedge CLK);
    Data_Valid = 1'b0;
    P_DATA = W'($urandom); PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom);
    while (busy === 1'b1 && n < 40) begin
      trace = {trace[61:0], mux_sel};
      if (mux_sel == 2'b10) bits = {ser_data, bits[W-1:1]};
      n++;
      Data_Valid = (n == inj);
      if (n == inj) begin
        P_DATA = 8'h55; PAR_EN = 1'b0; PAR_TYP = 1'b1;
      end
      @(negedge CLK);
    end
    Data_Valid = 1'b0;
    chk("frame_len", n, exp_len);
    chk("frame_par", {31'd0, par_bit}, {31'd0, exp_par});
  endtask

  logic [63:0] tr;
  logic [W-1:0] bt;

  initial begin
    RST = 1'b1; Data_Valid = 1'b1; P_DATA = 8'hFF; PAR_EN = 1'b1; PAR_TYP = 1'b1;
    repeat (2) @(negedge CLK);
    chk("rst_mux", {30'd0, mux_sel}, 32'h1);
    chk("rst_busy", {31'd0, busy}, 32'h0);
    chk("rst_ser", {31'd0, ser_data}, 32'h0);
    chk("rst_par", {31'd0, par_bit}, 32'h0);
    RST = 1'b0; Data_Valid = 1'b0;
    run_frame(8'hA5, 1'b1, 1'b0, -1, 11, 1'b0, tr, bt);
    chk("a5_trace", tr[31:0], 32'({22'b00_10_10_10_10_10_10_10_10_11_01}));
    chk("a5_bits", {24'd0, bt}, 32'hA5);
    run_frame(8'h03, 1'b1, 1'b1, -1, 11, 1'b1, tr, bt);
    chk("03_bits", {24'd0, bt}, 32'h03);
    run_frame(8'hFF, 1'b0, 1'b0, -1, 10, 1'b0, tr, bt);
    chk("ff_trace", tr[31:0], 32'({20'b00_10_10_10_10_10_10_10_10_01}));
    run_frame(8'hA5, 1'b1, 1'b0, 4, 11, 1'b0, tr, bt);
    chk("inj_bits", {24'd0, bt}, 32'hA5);
    chk("inj_trace", tr[31:0], 32'({22'b00_10_10_10_10_10_10_10_10_11_01}));
    @(negedge CLK);
    P_DATA = 8'hA5; PAR_EN = 1'b1; PAR_TYP = 1'b1; Data_Valid = 1'b1;
    @(negedge CLK);
    Data_Valid = 1'b0;
    repeat (4) @(negedge CLK);
    chk("mid_par", {31'd0, par_bit}, 32'h1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("abort_mux", {30'd0, mux_sel}, 32'h1);
    chk("abort_busy", {31'd0, busy}, 32'h0);
    chk("abort_par", {31'd0, par_bit}, 32'h0);
    repeat (3) @(negedge CLK);
    chk("abort_idle", {31'd0, busy}, 32'h0);
    run_frame(8'h3C, 1'b1, 1'b1, -1, 11, 1'b1, tr, bt);
    chk("post_bits", {24'd0, bt}, 32'h3C);
    repeat (60) begin
      @(negedge CLK);
      Data_Valid = 1'b1; P_DATA = W'($urandom); PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom);
    end
    repeat (3000) begin
      @(negedge CLK);
      RST = $urandom_range(0, 199) == 0;
      Data_Valid = $urandom_range(0, 3) != 0;
      P_DATA = W'($urandom); PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom);
    end
    @(negedge CLK);
    RST = 1'b0; Data_Valid = 1'b0;
    repeat (15) @(negedge CLK);
    chk("final_idle", {31'd0, busy}, 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving the number of payload bits per frame.
REQ-002 SHALL have port CLK  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port P_DATA  in  DATA_WIDTH  parallel payload, sampled at acceptance.
REQ-005 SHALL have port Data_Valid  in  1  payload-present strobe.
REQ-006 SHALL have port PAR_EN  in  1  1 = parity bit inserted, sampled at acceptance.
REQ-007 SHALL have port PAR_TYP  in  1  0 = even, 1 = odd, sampled at acceptance.
REQ-008 SHALL have port mux_sel  out  2  line-source select to the downstream Tx mux: 00 start, 01 stop/idle, 10 serial data, 11 parity.
REQ-009 SHALL have port ser_data  out  1  current payload bit.
REQ-010 SHALL have port par_bit  out  1  parity of the latched payload.
REQ-011 SHALL have port busy  out  1  frame in progress.

Function
REQ-012 SHALL implement the FSM states IDLE, START, DATA, PARITY and STOP; all outputs SHALL be registered.
REQ-013 SHALL accept a frame at an edge where state = IDLE and Data_Valid = 1 (acceptance edge k), latching P_DATA, PAR_EN and PAR_TYP into shadow registers.
REQ-014 SHALL ignore Data_Valid while busy = 1; there is no queueing and no error flag.
REQ-015 SHALL, after edge k, be in START with mux_sel = 00 and busy = 1 for exactly one cycle.
REQ-016 SHALL, after edge k+1+i (i = 0..DATA_WIDTH-1), be in DATA with mux_sel = 10 and ser_data = latched bit i, LSB first.
REQ-017 SHALL use a bit counter of width clog2(DATA_WIDTH) that clears on entering DATA; the FSM SHALL leave DATA when the counter = DATA_WIDTH-1.
REQ-018 SHALL, if the latched PAR_EN = 1, spend one cycle in PARITY with mux_sel = 11; otherwise it SHALL go directly from DATA to STOP.
REQ-019 SHALL spend one cycle in STOP with mux_sel = 01 and busy = 1, then enter IDLE.
REQ-020 SHALL hold mux_sel = 01 and busy = 0 in IDLE; frame length = 2 + DATA_WIDTH + PAR_EN cycles; there is at least one IDLE cycle between frames.
REQ-021 SHALL update par_bit at the acceptance edge to XOR-reduce(P_DATA) when PAR_TYP = 0, and to its inverse when PAR_TYP = 1, and hold it until the next acceptance.
REQ-022 SHALL hold ser_data at its last value outside DATA.
REQ-023 SHALL ignore changes to P_DATA, PAR_EN and PAR_TYP after acceptance until the frame ends.
REQ-024 SHALL account for the 1-cycle register delay of the downstream mux; each line bit lasts exactly one CLK cycle, and baud pacing comes from CLK itself.

Reset
REQ-025 SHALL, while RST = 1 at an edge, force state = IDLE, mux_sel = 01, ser_data = 0, par_bit = 0, busy = 0, and clear the counter and shadow registers.
REQ-026 SHALL give RST priority over Data_Valid at the same edge; a frame SHALL NOT be accepted.
REQ-027 SHALL abort any frame in progress when RST is asserted mid-frame, with no partial completion after RST is released.

Verification
REQ-028 SHALL pass: P_DATA = 0xA5, PAR_EN = 1, PAR_TYP = 0 -> mux_sel 00, 10x8, 11, 01; ser_data 1,0,1,0,0,1,0,1; par_bit = 0; busy high for 11 cycles.
REQ-029 SHALL pass: P_DATA = 0x03, PAR_EN = 1, PAR_TYP = 1 -> par_bit = 1; frame of 11 cycles.
REQ-030 SHALL pass: P_DATA = 0xFF, PAR_EN = 0 -> no 11 cycle; busy high for 10 cycles; mux_sel goes from 10 directly to 01.
REQ-031 SHALL pass: Data_Valid pulsed with P_DATA = 0x55 during the DATA state of an 0xA5 frame -> 0xA5 frame unchanged, 0x55 never transmitted.
REQ-032 SHALL pass: RST asserted at the 4th DATA cycle -> next cycle mux_sel = 01, busy = 0, par_bit = 0; a new Data_Valid after release starts a clean frame.
REQ-033 SHALL pass: Data_Valid held high continuously -> exactly one IDLE cycle between frames; every frame length matches REQ-020.
